// File: rtl/prbs_gen_multi.sv
// Multi-channel PRBS source (PRBS7/9/15/23/31) with seed reload, error injection and
// registered valid/sync flags. One prbs_lane per channel; top owns mode and flags.

module prbs_lane #(
  parameter int                 NB_PAR  = 1,
  parameter int                 NB_LFSR = 31,
  parameter logic [NB_LFSR-1:0] SEED    = '1
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [2:0]        i_mode,
  input  logic [2:0]        i_load_mode,
  input  logic              i_inj,
  output logic [NB_PAR-1:0] o_word
);

  function automatic logic [NB_LFSR-1:0] len_mask(input logic [2:0] m);
    logic [NB_LFSR-1:0] r;
    r = '0;
    case (m)
      3'd0:    r[6:0]  = '1;
      3'd2:    r[14:0] = '1;
      3'd3:    r[22:0] = '1;
      3'd4:    r[30:0] = '1;
      default: r[8:0]  = '1;
    endcase
    return r;
  endfunction

  // A zero seed would lock the register, so fall back to all-ones.
  function automatic logic [NB_LFSR-1:0] seed_val(input logic [2:0] m);
    logic [NB_LFSR-1:0] v;
    v = SEED & len_mask(m);
    if (v == '0) v = len_mask(m);
    return v;
  endfunction

  function automatic logic [NB_LFSR-1:0] lfsr_step(input logic [NB_LFSR-1:0] s,
                                                   input logic [2:0] m);
    logic [NB_LFSR-1:0] n;
    n = '0;
    case (m)
      3'd0:    n[6:0]  = {s[0] ^ s[1], s[6:1]};
      3'd2:    n[14:0] = {s[0] ^ s[1], s[14:1]};
      3'd3:    n[22:0] = {s[0] ^ s[5], s[22:1]};
      3'd4:    n[30:0] = {s[0] ^ s[3], s[30:1]};
      default: n[8:0]  = {s[0] ^ s[5], s[8:1]};
    endcase
    return n;
  endfunction

  logic [NB_LFSR-1:0] r_state;
  logic [NB_LFSR-1:0] w_s;
  logic [NB_PAR-1:0]  w_word;
  logic [NB_PAR-1:0]  w_inj_vec;

  always_comb begin
    w_s       = r_state;
    w_word    = '0;
    w_inj_vec = '0;
    w_inj_vec[0] = i_inj;
    for (int k = 0; k < NB_PAR; k++) begin
      w_word[k] = w_s[0];
      w_s       = lfsr_step(w_s, i_mode);
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state <= seed_val(i_load_mode);
      o_word  <= '0;
    end else if (i_load) begin
      r_state <= seed_val(i_load_mode);
    end else if (i_step) begin
      r_state <= w_s;
      o_word  <= w_word ^ w_inj_vec;
    end
  end

endmodule

module prbs_gen_multi #(
  parameter int                        N_CH    = 2,
  parameter int                        NB_PAR  = 1,
  parameter int                        NB_LFSR = 31,
  parameter logic [N_CH*NB_LFSR-1:0]   SEED    = {31'h1FE, 31'h1AA}
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_enable2,
  input  logic                   i_load,
  input  logic [2:0]             i_mode,
  input  logic                   i_err_inj,
  input  logic [N_CH-1:0]        i_err_mask,
  output logic [N_CH*NB_PAR-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_sync,
  output logic [2:0]             o_mode
);

  logic [2:0] w_mode_in;
  logic       w_en;
  logic       w_step;
  logic       r_armed;

  assign w_mode_in = (i_mode > 3'd4) ? 3'd1 : i_mode;
  assign w_en      = i_enable & i_enable2;
  assign w_step    = w_en & ~i_load;

  always_ff @(posedge clock) begin
    if (i_reset || i_load) begin
      o_mode  <= w_mode_in;
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
      r_armed <= 1'b1;
    end else if (w_en) begin
      o_valid <= 1'b1;
      o_sync  <= r_armed;
      r_armed <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    prbs_lane #(
      .NB_PAR  (NB_PAR),
      .NB_LFSR (NB_LFSR),
      .SEED    (SEED[c*NB_LFSR +: NB_LFSR])
    ) u_lane (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_load      (i_load),
      .i_step      (w_step),
      .i_mode      (o_mode),
      .i_load_mode (w_mode_in),
      .i_inj       (i_err_inj & i_err_mask[c]),
      .o_word      (o_data[c*NB_PAR +: NB_PAR])
    );
  end

endmodule

// File: tb/tb_prbs_gen_multi.sv
// Directed bench for prbs_gen_multi: default build plus NB_PAR=4 and zero-seed builds on shared stimulus.

module tb_prbs_gen_multi;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0, i_enable = 1'b0, i_enable2 = 1'b0, i_load = 1'b0;
  logic [2:0] i_mode = 3'd1;
  logic       i_err_inj = 1'b0;
  logic [1:0] i_err_mask = 2'b00;

  logic [1:0] o_data;  logic o_valid;  logic o_sync;  logic [2:0] o_mode;
  logic [7:0] o_data4; logic o_valid4; logic o_sync4; logic [2:0] o_mode4;
  logic [1:0] o_dataz; logic o_validz; logic o_syncz; logic [2:0] o_modez;

  int errs = 0, checks = 0;

  always #5 clock = ~clock;

  prbs_gen_multi dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_enable2(i_enable2),
    .i_load(i_load), .i_mode(i_mode), .i_err_inj(i_err_inj), .i_err_mask(i_err_mask),
    .o_data(o_data), .o_valid(o_valid), .o_sync(o_sync), .o_mode(o_mode));

  prbs_gen_multi #(.NB_PAR(4)) dut4 (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_enable2(i_enable2),
    .i_load(i_load), .i_mode(i_mode), .i_err_inj(i_err_inj), .i_err_mask(i_err_mask),
    .o_data(o_data4), .o_valid(o_valid4), .o_sync(o_sync4), .o_mode(o_mode4));

  prbs_gen_multi #(.SEED({31'h1FE, 31'h180})) dutz (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_enable2(i_enable2),
    .i_load(i_load), .i_mode(i_mode), .i_err_inj(i_err_inj), .i_err_mask(i_err_mask),
    .o_data(o_dataz), .o_valid(o_validz), .o_sync(o_syncz), .o_mode(o_modez));

  // Bit-serial golden model of the default-seed DUT.
  logic [30:0] m_s [2];
  logic [30:0] m_seed [2];
  int m_L, m_T;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic model_load(input logic [2:0] m);
    logic [30:0] msk, v;
    case (m)
      3'd0: begin m_L = 7;  m_T = 1; end
      3'd2: begin m_L = 15; m_T = 1; end
      3'd3: begin m_L = 23; m_T = 5; end
      3'd4: begin m_L = 31; m_T = 3; end
      default: begin m_L = 9; m_T = 5; end
    endcase
    msk = 31'h7FFF_FFFF >> (31 - m_L);
    for (int c = 0; c < 2; c++) begin
      v = m_seed[c] & msk;
      m_s[c] = (v == 31'd0) ? msk : v;
    end
  endtask

  task automatic model_next(output logic [1:0] w);
    logic nb;
    for (int c = 0; c < 2; c++) begin
      w[c] = m_s[c][0];
      nb = m_s[c][0] ^ m_s[c][m_T];
      m_s[c] = m_s[c] >> 1;
      m_s[c][m_L-1] = nb;
    end
  endtask

  task automatic do_reset(input logic [2:0] m);
    i_reset = 1'b1; i_mode = m; i_enable = 1'b0; i_enable2 = 1'b1;
    i_load = 1'b0; i_err_inj = 1'b0; i_err_mask = 2'b00;
    tick();
    i_reset = 1'b0;
    model_load(m);
  endtask

  task automatic test_reset;
    do_reset(3'd1);
    checks++; if (o_data !== 2'b00) begin errs++; $display("FAIL reset_data got=%b exp=00", o_data); end
    checks++; if (o_valid !== 1'b0 || o_sync !== 1'b0) begin errs++; $display("FAIL reset_flags got v=%b s=%b exp v=0 s=0", o_valid, o_sync); end
    checks++; if (o_mode !== 3'd1) begin errs++; $display("FAIL reset_mode got=%0d exp=1", o_mode); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errs++; $display("FAIL idle_valid got=%b exp=0", o_valid); end
  endtask

  task automatic test_first_bits;
    logic [9:0] e0;
    logic [8:0] e1;
    logic [1:0] w;
    e0 = 10'h3AA;
    e1 = 9'h1FE;
    i_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      model_next(w);
      checks++; if (o_valid !== 1'b1 || o_sync !== (i == 0)) begin errs++; $display("FAIL first_flags[%0d] got v=%b s=%b exp v=1 s=%b", i, o_valid, o_sync, (i == 0)); end
      checks++; if (o_data[0] !== e0[i]) begin errs++; $display("FAIL first_ch0[%0d] got=%b exp=%b", i, o_data[0], e0[i]); end
      if (i < 9) begin
        checks++; if (o_data[1] !== e1[i]) begin errs++; $display("FAIL first_ch1[%0d] got=%b exp=%b", i, o_data[1], e1[i]); end
      end
      if (i == 0) begin
        checks++; if (o_data4 !== 8'hEA) begin errs++; $display("FAIL par4_word0 got=%h exp=ea", o_data4); end
        checks++; if (o_valid4 !== 1'b1 || o_sync4 !== 1'b1 || o_mode4 !== 3'd1) begin errs++; $display("FAIL par4_flags got v=%b s=%b m=%0d exp 1 1 1", o_valid4, o_sync4, o_mode4); end
      end
      if (i == 1) begin
        checks++; if (o_data4[3:0] !== 4'b1010) begin errs++; $display("FAIL par4_word1 got=%b exp=1010", o_data4[3:0]); end
      end
      if (i == 2) begin
        checks++; if (o_data4[3:0] !== 4'b1111) begin errs++; $display("FAIL par4_word2 got=%b exp=1111", o_data4[3:0]); end
      end
    end
  endtask

  task automatic test_stall;
    logic [1:0] w, last;
    for (int i = 0; i < 5; i++) begin
      tick(); model_next(w);
      checks++; if (o_data !== w) begin errs++; $display("FAIL stall_pre[%0d] got=%b exp=%b", i, o_data, w); end
    end
    last = w;
    i_enable2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (o_valid !== 1'b0 || o_sync !== 1'b0 || o_data !== last) begin errs++; $display("FAIL stall_hold[%0d] got v=%b s=%b d=%b exp v=0 s=0 d=%b", i, o_valid, o_sync, o_data, last); end
    end
    i_enable2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); model_next(w);
      checks++; if (o_data !== w || o_valid !== 1'b1) begin errs++; $display("FAIL stall_resume[%0d] got d=%b v=%b exp d=%b v=1", i, o_data, o_valid, w); end
    end
  endtask

  task automatic test_inject;
    logic [1:0] w, last;
    i_err_inj = 1'b1; i_err_mask = 2'b01;
    tick(); model_next(w);
    checks++; if (o_data !== (w ^ 2'b01)) begin errs++; $display("FAIL inject_word got=%b exp=%b", o_data, w ^ 2'b01); end
    i_err_inj = 1'b0;
    tick(); model_next(w);
    checks++; if (o_data !== w) begin errs++; $display("FAIL inject_after got=%b exp=%b", o_data, w); end
    last = w;
    i_enable = 1'b0; i_err_inj = 1'b1; i_err_mask = 2'b11;
    tick();
    checks++; if (o_data !== last || o_valid !== 1'b0) begin errs++; $display("FAIL inject_noen got d=%b v=%b exp d=%b v=0", o_data, o_valid, last); end
    i_enable = 1'b1; i_err_inj = 1'b0; i_err_mask = 2'b00;
    tick(); model_next(w);
    checks++; if (o_data !== w) begin errs++; $display("FAIL inject_noen_next got=%b exp=%b", o_data, w); end
  endtask

  task automatic test_mode_ignore;
    logic [1:0] w;
    i_mode = 3'd3;
    tick(); model_next(w);
    checks++; if (o_mode !== 3'd1 || o_data !== w) begin errs++; $display("FAIL mode_ignore got m=%0d d=%b exp m=1 d=%b", o_mode, o_data, w); end
    i_mode = 3'd1;
  endtask

  task automatic test_load;
    logic [1:0] w;
    i_load = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0 || o_sync !== 1'b0) begin errs++; $display("FAIL load_cycle got v=%b s=%b exp v=0 s=0", o_valid, o_sync); end
    i_load = 1'b0;
    model_load(3'd1);
    tick(); model_next(w);
    checks++; if (o_valid !== 1'b1 || o_sync !== 1'b1 || o_data !== w) begin errs++; $display("FAIL load_restart got v=%b s=%b d=%b exp v=1 s=1 d=%b", o_valid, o_sync, o_data, w); end
    tick(); model_next(w);
    checks++; if (o_sync !== 1'b0 || o_data !== w) begin errs++; $display("FAIL load_second got s=%b d=%b exp s=0 d=%b", o_sync, o_data, w); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] w;
    i_reset = 1'b1; i_mode = 3'd7;
    tick();
    checks++; if (o_mode !== 3'd1 || o_data !== 2'b00 || o_valid !== 1'b0 || o_sync !== 1'b0) begin errs++; $display("FAIL reset_mid got m=%0d d=%b v=%b s=%b exp m=1 d=00 v=0 s=0", o_mode, o_data, o_valid, o_sync); end
    i_reset = 1'b0;
    model_load(3'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); model_next(w);
      checks++; if (o_data !== w || o_sync !== (i == 0)) begin errs++; $display("FAIL reset_mid_stream[%0d] got d=%b s=%b exp d=%b s=%b", i, o_data, o_sync, w, (i == 0)); end
    end
  endtask

  task automatic test_zero_seed;
    logic [7:0] ez0, ez1;
    ez0 = 8'h7F;
    ez1 = 8'hFE;
    do_reset(3'd0);
    checks++; if (o_modez !== 3'd0) begin errs++; $display("FAIL zseed_mode got=%0d exp=0", o_modez); end
    i_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (o_dataz[0] !== ez0[i] || o_dataz[1] !== ez1[i] || o_validz !== 1'b1 || o_syncz !== (i == 0)) begin
        errs++; $display("FAIL zseed_bit[%0d] got d=%b v=%b s=%b exp d=%b%b v=1 s=%b", i, o_dataz, o_validz, o_syncz, ez1[i], ez0[i], (i == 0));
      end
    end
  endtask

  task automatic test_period(input logic [2:0] m, input int L);
    logic [1:0] w;
    logic [30:0] sm0;
    int period, mism, wrap_mism, run0, run1, maxrun;
    period = (1 << L) - 1;
    mism = 0; wrap_mism = 0; run0 = 0; run1 = 0; maxrun = 0;
    do_reset(m);
    sm0 = m_s[0];
    checks++; if (o_mode !== m) begin errs++; $display("FAIL period_mode got=%0d exp=%0d", o_mode, m); end
    i_enable = 1'b1;
    for (int k = 0; k < period + L; k++) begin
      tick(); model_next(w);
      if (o_data !== w || o_valid !== 1'b1) mism++;
      if (k >= period && o_data[0] !== sm0[k - period]) wrap_mism++;
      run0 = (o_data[0] === 1'b0) ? run0 + 1 : 0;
      run1 = (o_data[1] === 1'b0) ? run1 + 1 : 0;
      if (run0 > maxrun) maxrun = run0;
      if (run1 > maxrun) maxrun = run1;
    end
    i_enable = 1'b0;
    checks++; if (mism != 0) begin errs++; $display("FAIL period_stream m=%0d mismatches=%0d exp=0", m, mism); end
    checks++; if (wrap_mism != 0) begin errs++; $display("FAIL period_wrap m=%0d mismatches=%0d exp=0", m, wrap_mism); end
    checks++; if (maxrun >= L) begin errs++; $display("FAIL period_zero_run m=%0d run=%0d exp<%0d", m, maxrun, L); end
  endtask

  initial begin
    m_seed[0] = 31'h1AA;
    m_seed[1] = 31'h1FE;
    test_reset();
    test_first_bits();
    test_stall();
    test_inject();
    test_mode_ignore();
    test_load();
    test_reset_mid();
    test_zero_seed();
    test_period(3'd1, 9);
    test_period(3'd0, 7);
    test_period(3'd2, 15);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/prbs_gen_multi.md
Name: prbs_gen_multi

Overview:
- Parametrised multi-channel PRBS generator; successor to the single-polynomial, two-channel (I/Q) PRBS9 source in the RCTX transmit path.
- Runtime-selectable polynomial (PRBS7/9/15/23/31), NB_PAR bits per enabled cycle, registered outputs with valid/sync flags.
- Per-channel seed reload and error injection for BER/link testing.
- Feeds the symbol mapper; one channel per I/Q rail by default.

Parameters:
- N_CH, 2, number of independent LFSR channels.
- NB_PAR, 1, bits produced per channel per enabled cycle (1..8).
- NB_LFSR, 31, physical LFSR register width; fixed, sized for PRBS31.
- SEED, {31'h1FE, 31'h1AA}, concatenated per-channel seeds, N_CH*NB_LFSR bits; ch0 in the LSBs.

Ports:
- clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  step enable (switch); a step occurs only when i_enable & i_enable2.
- i_enable2  in  1  step enable (control/rate strobe).
- i_load  in  1  reload all seeds and latch i_mode.
- i_mode  in  3  polynomial select; sampled only at reset or i_load.
- i_err_inj  in  1  inject an error into the current step's output.
- i_err_mask  in  N_CH  channels affected by i_err_inj.
- o_data  out  N_CH*NB_PAR  channel c at [c*NB_PAR +: NB_PAR]; bit 0 is the earliest bit in time.
- o_valid  out  1  o_data holds a new word.
- o_sync  out  1  o_data holds the first word after reset/load.
- o_mode  out  3  active (latched) mode.

Behaviour:
- Mode table (L = length, T = tap index), each mode applied to state s[L-1:0]:
  - 0: PRBS7, L=7, T=1.
  - 1: PRBS9, L=9, T=5.
  - 2: PRBS15, L=15, T=1.
  - 3: PRBS23, L=23, T=5.
  - 4: PRBS31, L=31, T=3.
  - 5..7: treated as mode 1.
- One bit-step: output s[0]; s <= s >> 1; s[L-1] <= s[0] ^ s[T]. Bits above L-1 are held at 0.
- PRBS9 bit-for-bit matches the legacy I/Q generator when N_CH=2, NB_PAR=1 and seeds are at default.
- Seed load: per channel, SEED slice masked to L bits. If the masked value is 0, load all-ones (2^L-1) so the LFSR cannot lock up.
- Reset:
  - mode register <= i_mode (5..7 stored as 1); seeds loaded.
  - o_data=0, o_valid=0, o_sync=0, o_mode=latched value.
  - Next valid word has o_sync=1.
- Step (en = i_enable & i_enable2, i_load=0):
  - o_data gets NB_PAR consecutive bit-steps per channel, computed combinationally in one cycle.
  - State advances NB_PAR steps; o_valid=1 in the following cycle (1-cycle latency).
  - o_sync=1 only on the first valid word after reset/load, otherwise 0.
- No step (en=0): state held, o_data held, o_valid=0, o_sync=0.
- Error injection: if i_err_inj & en, bit 0 of the word for each channel c with i_err_mask[c]=1 is inverted. LFSR state is not affected; i_err_inj without en is ignored.
- Priority: i_reset > i_load > step.
  - i_load with en high: load wins, no word emitted, o_valid=0.
  - Sync flag is re-armed on load.
- i_mode changes without i_load: ignored; o_mode is unchanged.
- Period: the bit stream of each channel repeats every 2^L-1 bits.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Default params, reset, en=1 continuous:
  - ch0 first 10 bits 0,1,0,1,0,1,0,1,1,1.
  - ch1 first 9 bits 0,1,1,1,1,1,1,1,1.
  - o_sync=1 only on the 1st valid cycle; o_valid first high the cycle after en.
- Mode 1, en=1 for 511 steps: internal state and output stream return to seed 0x1AA; no all-zero state seen. Repeat for mode 0 (127 steps) and mode 2 (32767 steps).
- Mode 0, SEED ch0=31'h180:
  - masked seed is 0, so the channel loads 0x7F.
  - first 7 bits all 1; 8th bit = 1^1 = 0.
- NB_PAR=4, mode 1, default seeds: first ch0 word o_data[3:0]=4'b1010; second word = 4'b1010 (seed bits 4..7 = 0,1,0,1).
- Load/stall/inject:
  - Toggle i_enable2 low 3 cycles mid-stream: stream resumes with no bits lost or repeated.
  - i_err_inj with mask 2'b01: only ch0 bit 0 inverted in that word; next word matches the golden model.
  - i_load together with en: o_valid=0 that cycle, then the stream restarts from seed with o_sync=1.
- i_reset asserted mid-stream with i_mode=7: o_mode=1, outputs zero next cycle, stream restarts from seeds.
